// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: schedules pattern, LTSM and adapter words
// onto one serializer with packet locking and a stall watchdog.
module sb_tx_arbiter #(
    parameter int DATA_W        = 64,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pat_valid,
    input  logic [DATA_W-1:0] i_pat_data,
    output logic              o_pat_ack,
    input  logic              i_ltsm_valid,
    input  logic [DATA_W-1:0] i_ltsm_data,
    input  logic              i_ltsm_last,
    output logic              o_ltsm_ack,
    input  logic              i_adp_valid,
    input  logic [DATA_W-1:0] i_adp_data,
    input  logic              i_adp_last,
    output logic              o_adp_ack,
    input  logic              i_ser_ready,
    output logic [DATA_W-1:0] o_ser_data,
    output logic              o_ser_valid,
    output logic [1:0]        o_owner,
    output logic              o_stall_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_LTSM,
        LOCK_ADP
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(STALL_TIMEOUT);

    state_t            state_q, state_d;
    logic              rr_adp_q, rr_adp_d;
    logic [7:0]        stall_q, stall_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              pick_adp;
    logic              x_valid;
    logic              x_last;
    logic [DATA_W-1:0] x_data;

    assign can_load    = !valid_q || i_ser_ready;
    assign o_ser_data  = data_q;
    assign o_ser_valid = valid_q;

    // Word source of the current lock owner
    always_comb begin
        x_valid = i_ltsm_valid;
        x_last  = i_ltsm_last;
        x_data  = i_ltsm_data;
        if (state_q == LOCK_ADP) begin
            x_valid = i_adp_valid;
            x_last  = i_adp_last;
            x_data  = i_adp_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_adp_d    = rr_adp_q;
        stall_d     = stall_q;
        load        = 1'b0;
        load_data   = i_pat_data;
        pick_adp    = 1'b0;
        o_pat_ack   = 1'b0;
        o_ltsm_ack  = 1'b0;
        o_adp_ack   = 1'b0;
        o_owner     = 2'd0;
        o_stall_err = 1'b0;
        if (i_rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (can_load && i_pat_valid) begin
                        load      = 1'b1;
                        load_data = i_pat_data;
                        o_pat_ack = 1'b1;
                        o_owner   = 2'd1;
                    end else if (can_load && (i_ltsm_valid || i_adp_valid)) begin
                        pick_adp = i_adp_valid && (!i_ltsm_valid || rr_adp_q);
                        load     = 1'b1;
                        rr_adp_d = !pick_adp;
                        if (pick_adp) begin
                            load_data = i_adp_data;
                            o_adp_ack = 1'b1;
                            o_owner   = 2'd3;
                            if (!i_adp_last) state_d = LOCK_ADP;
                        end else begin
                            load_data  = i_ltsm_data;
                            o_ltsm_ack = 1'b1;
                            o_owner    = 2'd2;
                            if (!i_ltsm_last) state_d = LOCK_LTSM;
                        end
                    end
                end
                LOCK_LTSM, LOCK_ADP: begin
                    o_owner = (state_q == LOCK_ADP) ? 2'd3 : 2'd2;
                    if (x_valid) begin
                        if (can_load) begin
                            load       = 1'b1;
                            load_data  = x_data;
                            stall_d    = 8'd0;
                            o_ltsm_ack = (state_q == LOCK_LTSM);
                            o_adp_ack  = (state_q == LOCK_ADP);
                            if (x_last) state_d = IDLE;
                        end
                    end else if (stall_q + 8'd1 >= TIMEOUT) begin
                        state_d     = IDLE;
                        stall_d     = 8'd0;
                        o_stall_err = 1'b1;
                    end else begin
                        stall_d = stall_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rr_adp_q <= 1'b0;
            stall_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_adp_q <= rr_adp_d;
            stall_q  <= stall_d;
        end
    end

    // Single-entry output register toward the serializer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (i_ser_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed vector bench for sb_tx_arbiter: arbitration order,
// back-pressure, watchdog release and reset mid-packet.
module tb_sb_tx_arbiter;

    localparam logic [63:0] P  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] L1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] L2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] A1 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] A2 = 64'h4444_4444_4444_4444;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pat_valid, ltsm_valid, ltsm_last;
    logic        adp_valid, adp_last, ser_ready;
    logic [63:0] pat_data, ltsm_data, adp_data;
    logic        pat_ack, ltsm_ack, adp_ack;
    logic [63:0] ser_data;
    logic        ser_valid, stall_err;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sb_tx_arbiter #(.DATA_W(64), .STALL_TIMEOUT(15)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pat_valid (pat_valid),
        .i_pat_data  (pat_data),
        .o_pat_ack   (pat_ack),
        .i_ltsm_valid(ltsm_valid),
        .i_ltsm_data (ltsm_data),
        .i_ltsm_last (ltsm_last),
        .o_ltsm_ack  (ltsm_ack),
        .i_adp_valid (adp_valid),
        .i_adp_data  (adp_data),
        .i_adp_last  (adp_last),
        .o_adp_ack   (adp_ack),
        .i_ser_ready (ser_ready),
        .o_ser_data  (ser_data),
        .o_ser_valid (ser_valid),
        .o_owner     (owner),
        .o_stall_err (stall_err)
    );

    // flags = {pat_ack, ltsm_ack, adp_ack, owner[1:0], stall_err, ser_valid}
    typedef struct {
        logic        pv;
        logic [63:0] pd;
        logic        lv;
        logic [63:0] ld;
        logic        ll;
        logic        av;
        logic [63:0] ad;
        logic        al;
        logic        rdy;
        logic [6:0]  ef;
        logic [63:0] ed;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm,
                       input logic pv, input logic [63:0] pd,
                       input logic lv, input logic [63:0] ld, input logic ll,
                       input logic av, input logic [63:0] ad, input logic al,
                       input logic rdy,
                       input logic pa, input logic la, input logic aa,
                       input logic [1:0] own, input logic st,
                       input logic sv, input logic [63:0] sd);
        vec_t v;
        v.name = nm;
        v.pv = pv; v.pd = pd;
        v.lv = lv; v.ld = ld; v.ll = ll;
        v.av = av; v.ad = ad; v.al = al;
        v.rdy = rdy;
        v.ef = {pa, la, aa, own, st, sv};
        v.ed = sd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [6:0] ef,
                       input logic [63:0] ed);
        logic [6:0] af;
        af = {pat_ack, ltsm_ack, adp_ack, owner, stall_err, ser_valid};
        checks++;
        if (af !== ef || (ef[0] && ser_data !== ed)) begin
            errors++;
            $display("FAIL %s: flags got %b want %b data got %h want %h",
                     nm, af, ef, ser_data, ed);
        end
    endtask

    task automatic drive(input vec_t v);
        pat_valid  = v.pv; pat_data  = v.pd;
        ltsm_valid = v.lv; ltsm_data = v.ld; ltsm_last = v.ll;
        adp_valid  = v.av; adp_data  = v.ad; adp_last  = v.al;
        ser_ready  = v.rdy;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        chk(v.name, v.ef, v.ed);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        pat_valid = 0; pat_data = '0;
        ltsm_valid = 0; ltsm_data = '0; ltsm_last = 0;
        adp_valid = 0; adp_data = '0; adp_last = 0;
        ser_ready = 0;

        // round robin from reset: LTSM, ADP, LTSM, ADP
        add("rr0", 0,P, 1,L1,1, 1,A1,1, 1, 0,1,0,2'd2,0, 0,0);
        add("rr1", 0,P, 1,L1,1, 1,A1,1, 1, 0,0,1,2'd3,0, 1,L1);
        add("rr2", 0,P, 1,L1,1, 1,A1,1, 1, 0,1,0,2'd2,0, 1,A1);
        add("rr3", 0,P, 1,L1,1, 1,A1,1, 1, 0,0,1,2'd3,0, 1,L1);
        add("rr4", 0,P, 0,L1,1, 0,A1,1, 1, 0,0,0,2'd0,0, 1,A1);
        add("rr5", 0,P, 0,L1,1, 0,A1,1, 1, 0,0,0,2'd0,0, 0,0);
        // pattern held valid 4 cycles
        add("pat0", 1,P, 0,L1,0, 0,A1,0, 1, 1,0,0,2'd1,0, 0,0);
        add("pat1", 1,P, 0,L1,0, 0,A1,0, 1, 1,0,0,2'd1,0, 1,P);
        add("pat2", 1,P, 0,L1,0, 0,A1,0, 1, 1,0,0,2'd1,0, 1,P);
        add("pat3", 1,P, 0,L1,0, 0,A1,0, 1, 1,0,0,2'd1,0, 1,P);
        add("pat4", 0,P, 0,L1,0, 0,A1,0, 1, 0,0,0,2'd0,0, 1,P);
        add("pat5", 0,P, 0,L1,0, 0,A1,0, 1, 0,0,0,2'd0,0, 0,0);
        // LTSM packet locks out pattern
        add("lck0", 0,P, 1,L1,0, 0,A1,0, 1, 0,1,0,2'd2,0, 0,0);
        add("lck1", 1,P, 1,L2,1, 0,A1,0, 1, 0,1,0,2'd2,0, 1,L1);
        add("lck2", 1,P, 0,L2,0, 0,A1,0, 1, 1,0,0,2'd1,0, 1,L2);
        add("lck3", 0,P, 0,L2,0, 0,A1,0, 1, 0,0,0,2'd0,0, 1,P);
        add("lck4", 0,P, 0,L2,0, 0,A1,0, 1, 0,0,0,2'd0,0, 0,0);
        // back-pressure: ready low 5 cycles
        add("bp0", 0,P, 0,L1,0, 1,A1,1, 1, 0,0,1,2'd3,0, 0,0);
        for (int i = 0; i < 5; i++)
            add("bp_hold", 0,P, 0,L1,0, 1,A2,1, 0, 0,0,0,2'd0,0, 1,A1);
        add("bp6", 0,P, 0,L1,0, 1,A2,1, 1, 0,0,1,2'd3,0, 1,A1);
        add("bp7", 0,P, 0,L1,0, 0,A2,1, 1, 0,0,0,2'd0,0, 1,A2);
        add("bp8", 0,P, 0,L1,0, 0,A2,1, 1, 0,0,0,2'd0,0, 0,0);
        // locked owner valid but blocked: watchdog must not fire
        add("blk0", 0,P, 1,L1,0, 0,A1,0, 1, 0,1,0,2'd2,0, 0,0);
        for (int i = 0; i < 16; i++)
            add("blk_hold", 0,P, 1,L2,1, 0,A1,0, 0, 0,0,0,2'd2,0, 1,L1);
        add("blk17", 0,P, 1,L2,1, 0,A1,0, 1, 0,1,0,2'd2,0, 1,L1);
        add("blk18", 0,P, 0,L2,1, 0,A1,0, 1, 0,0,0,2'd0,0, 1,L2);
        add("blk19", 0,P, 0,L2,1, 0,A1,0, 1, 0,0,0,2'd0,0, 0,0);
        // adapter stalls mid-packet, LTSM waiting
        add("stl0", 0,P, 0,L1,1, 1,A1,0, 1, 0,0,1,2'd3,0, 0,0);
        add("stl1", 0,P, 1,L1,1, 0,A1,0, 1, 0,0,0,2'd3,0, 1,A1);
        for (int i = 2; i < 15; i++)
            add("stl_wait", 0,P, 1,L1,1, 0,A1,0, 1, 0,0,0,2'd3,0, 0,0);
        add("stl15", 0,P, 1,L1,1, 0,A1,0, 1, 0,0,0,2'd3,1, 0,0);
        add("stl16", 0,P, 1,L1,1, 0,A1,0, 1, 0,1,0,2'd2,0, 0,0);
        add("stl17", 0,P, 0,L1,1, 0,A1,0, 1, 0,0,0,2'd0,0, 1,L1);
        add("stl18", 0,P, 0,L1,1, 0,A1,0, 1, 0,0,0,2'd0,0, 0,0);

        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset", 7'b0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // reset while LOCK_LTSM with a word registered
        v = tbl[0];
        v.name = "rst_lock"; v.av = 0; v.ll = 0;
        v.ef = {1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        apply(v);
        @(negedge clk);
        rst_n = 1'b0;
        ltsm_valid = 1; ltsm_last = 1;
        adp_valid = 1; adp_last = 1;
        ser_ready = 1;
        #2;
        chk("rst_held", 7'b0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst_first_pick", {1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0}, 64'h0);
        @(negedge clk);
        #2;
        chk("rst_second_pick", {1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1}, L1);
        @(negedge clk);
        ltsm_valid = 0; adp_valid = 0;
        #2;
        chk("rst_drain", {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1}, A1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_tx_arbiter.md
Name: sb_tx_arbiter

Overview:
- Schedules the single sideband serializer between three word sources: the SB pattern generator, the LTSM sideband message encoder and the adapter (FDI/RDI) message encoder.
- Serializer words are 64 bits wide.
- Packets of one or more words are never interleaved.
- The pattern source has strict priority at packet boundaries. The two message sources share the remaining bandwidth round-robin.
- A stall watchdog releases a packet lock whose owner stops supplying words.

Parameters:
- DATA_W, 64, serializer word width.
- STALL_TIMEOUT, 15, cycles a locked owner may hold valid low mid-packet before the lock is force-released (1..255).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_pat_valid  input  1  pattern word available (single-word packet).
- i_pat_data  input  DATA_W  pattern word.
- o_pat_ack  output  1  one-cycle pulse: pattern word taken.
- i_ltsm_valid  input  1  LTSM message word available.
- i_ltsm_data  input  DATA_W  LTSM word.
- i_ltsm_last  input  1  current LTSM word ends its packet.
- o_ltsm_ack  output  1  one-cycle pulse: LTSM word taken.
- i_adp_valid  input  1  adapter message word available.
- i_adp_data  input  DATA_W  adapter word.
- i_adp_last  input  1  current adapter word ends its packet.
- o_adp_ack  output  1  one-cycle pulse: adapter word taken.
- i_ser_ready  input  1  serializer can accept a word this cycle (level).
- o_ser_data  output  DATA_W  word to serializer.
- o_ser_valid  output  1  o_ser_data valid.
- o_owner  output  2  current lock owner: 0 none, 1 pattern, 2 LTSM, 3 adapter.
- o_stall_err  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset: all outputs 0. State IDLE, rr_next = LTSM, stall counter 0, output register empty.

Output register (one entry):
- Transfer occurs when o_ser_valid && i_ser_ready.
- can_load = !o_ser_valid || i_ser_ready.
- On a load: o_ser_data/o_ser_valid are updated at the next edge, and the granted source's ack pulses in the same cycle as the load decision, combinationally from registered state.
- Latency: source valid in cycle N (IDLE, register empty) -> ack in N, o_ser_valid=1 in N+1.
- If i_ser_ready is held high, one word moves per cycle with no bubbles.

State machine: IDLE, LOCK_LTSM, LOCK_ADP.
- IDLE, can_load:
  - i_pat_valid wins; load the pattern word and stay IDLE (a pattern packet is always one word).
  - Else, if both message sources are valid, pick rr_next. Otherwise pick whichever message source is valid.
  - Load that word and toggle rr_next to the other message source.
  - If the loaded word has last=1, stay IDLE; else go to LOCK_x.
- LOCK_x, can_load, x valid: load x's word. last=1 -> IDLE. Pattern and the other message source are ignored while locked.
- LOCK_x, x valid low: the stall counter increments each cycle. It clears on every x load and on leaving LOCK_x.
  - Counter reaching STALL_TIMEOUT: go to IDLE, pulse o_stall_err, clear counter.
  - Words already in the output register are still delivered.
- Without can_load, no ack is issued and state holds. The watchdog does not count while x is valid but can_load=0.
- o_owner: 1 in the cycle a pattern load happens, 2/3 in LOCK_LTSM/LOCK_ADP or on a message load, 0 otherwise.

Invariants:
- At most one ack per cycle.
- Data is never dropped or duplicated.
- o_ser_data is stable while o_ser_valid && !i_ser_ready.

Reset mid-packet: asserting i_rst_n low immediately clears everything. A partial packet is lost. Sources must be reset concurrently.

Test Plan:
- Pattern only, i_ser_ready=1, i_pat_valid held 4 cycles with data 0xAAAA_AAAA_AAAA_AAAA -> o_pat_ack high 4 cycles; o_ser_valid high cycles 1-4 after start with the same data; o_owner=1 on ack cycles.
- LTSM 2-word packet (last on word 2) plus pattern valid raised after word 1 -> the pattern is held off until LTSM word 2 is taken. Serializer sees LTSM1, LTSM2, PAT.
- LTSM and adapter both continuously valid, single-word packets, ready=1 -> acks alternate LTSM, ADP, LTSM, ADP, starting with LTSM after reset.
- i_ser_ready low for 5 cycles with a word loaded -> o_ser_data/o_ser_valid stable, no acks. When ready rises, the next word loads in that same cycle.
- Adapter sends word 1 (last=0), then drops valid for 15 cycles -> o_stall_err pulse in cycle 15, o_owner returns to 0, and a pending LTSM word is acked in the following cycle.
- Reset asserted while LOCK_LTSM with a word in the output register -> o_ser_valid=0, o_owner=0, and the first post-reset arbitration picks LTSM when both message sources are valid.
